// File: rtl/block_data_memory_pkg.sv
// Shared encodings and helpers for the line-granular backing memory.
// Imported by the memory top and its latency timer.
package block_data_memory_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/block_data_memory_mem_latency_timer.sv
// Down-counter that fires done exactly LATENCY edges after load.
// Ignores load while already running; the owner only loads from idle.
module mem_latency_timer
  import block_data_memory_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CW = clog2(LATENCY + 1);

  logic [CW-1:0] count;
  logic          running;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load && !running) begin
      count   <= CW'(LATENCY - 1);
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - CW'(1);
      end
    end
  end

  assign done = running && (count == '0);

endmodule

// File: rtl/block_data_memory.sv
// Line-granular backing memory behind the data cache: one whole-line read or
// write at a time, completed a fixed LATENCY edges after acceptance.
module block_data_memory
  import block_data_memory_pkg::*;
#(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 256,
  parameter int LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int OW = clog2(BLOCK_SIZE);
  localparam int IW = clog2(NUM_BLOCKS);
  localparam int DW = BLOCK_SIZE * 8;

  mem_state_t    state;
  mem_state_t    state_nxt;
  mem_op_t       op_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] lines [NUM_BLOCKS];

  logic accept;
  logic done;
  logic finish;
  logic unused_addr_bits;

  // Offset and high address bits play no part; high bits alias modulo NUM_BLOCKS.
  assign unused_addr_bits = ^{addr[31:OW+IW], addr[OW-1:0]};

  assign mem_ready = (state == MEM_IDLE) && reset;
  assign accept    = mem_ready && is_input_valid && (mem_read ^ mem_write);

  mem_latency_timer #(
    .LATENCY (LATENCY)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .done  (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (accept) begin
          state_nxt = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (done) begin
          finish    = 1'b1;
          state_nxt = MEM_IDLE;
        end
      end
      default: state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= OP_READ;
      idx_q <= '0;
      din_q <= '0;
    end else if (accept) begin
      op_q  <= mem_write ? OP_WRITE : OP_READ;
      idx_q <= addr[OW+IW-1:OW];
      din_q <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_output_valid <= 1'b0;
      dout            <= '0;
    end else begin
      is_output_valid <= 1'b0;
      if (finish && (op_q == OP_READ)) begin
        dout            <= lines[idx_q];
        is_output_valid <= 1'b1;
      end
    end
  end

  // Array contents survive reset; a discarded write never reaches here because
  // reset forces the FSM out of BUSY.
  always_ff @(posedge clk) begin
    if (finish && (op_q == OP_WRITE)) begin
      lines[idx_q] <= din_q;
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Scoreboard bench for block_data_memory: directed scenarios plus random traffic
// checked against a line-array model with per-request response deadlines.
module tb_block_data_memory;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [127:0] din = '0;
  logic         is_output_valid;
  logic [127:0] dout;
  logic         mem_ready;

  block_data_memory #(
    .BLOCK_SIZE (16),
    .NUM_BLOCKS (256),
    .LATENCY    (LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .mem_ready       (mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] ref_mem [256];
  logic [127:0] exp_dout = '0;
  int           busy_start = 0;
  int           busy_end = 0;
  int           vectors = 0;
  int           miscompares = 0;

  function automatic int line_idx(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd256);
  endfunction

  // Monitor: expected ready comes from the busy window of the last accepted request.
  always @(negedge clk) begin : mon
    bit   ready_exp;
    exp_t e;
    ready_exp = reset && !(cyc >= busy_start && cyc < busy_end);
    vectors++;
    if (mem_ready !== ready_exp) begin
      miscompares++;
      $display("FAIL mem_ready cyc=%0d got %b want %b", cyc, mem_ready, ready_exp);
    end
    if (!reset) begin
      exp_dout = '0;
      vectors++;
      if (is_output_valid !== 1'b0 || dout !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got valid=%b dout=%h want 0/0", cyc, is_output_valid, dout);
      end
    end else if (is_output_valid === 1'b1) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid cyc=%0d dout=%h", cyc, dout);
      end else begin
        e = sbq.pop_front();
        if (dout !== e.d || cyc != e.c) begin
          miscompares++;
          $display("FAIL read_resp cyc=%0d got %h want %h at cyc %0d", cyc, dout, e.d, e.c);
        end
        exp_dout = e.d;
      end
    end else begin
      vectors++;
      if (is_output_valid !== 1'b0 || dout !== exp_dout) begin
        miscompares++;
        $display("FAIL dout_hold cyc=%0d got valid=%b dout=%h want 0/%h", cyc, is_output_valid, dout, exp_dout);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accept edge.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [127:0] d, input bit model);
    int   n;
    exp_t e;
    n = 0;
    while (mem_ready !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout cyc=%0d got mem_ready=%b want 1", cyc, mem_ready);
      return;
    end
    is_input_valid = 1'b1;
    mem_read   = !wr;
    mem_write  = wr;
    addr       = a;
    din        = d;
    busy_start = cyc + 1;
    busy_end   = cyc + 1 + LAT;
    if (!wr) begin
      e.d = ref_mem[line_idx(a)];
      e.c = cyc + 1 + LAT;
      sbq.push_back(e);
    end else if (model) begin
      ref_mem[line_idx(a)] = d;
    end
    step(1);
    is_input_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset(input int k);
    reset      = 1'b0;
    busy_start = 0;
    busy_end   = 0;
    sbq.delete();
    step(k);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0]  ra;
    logic [127:0] rd;
    int           n;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Reset held for three cycles.
    #1;
    do_reset(3);
    step(2);

    // Write then read the same line at a different offset.
    issue(1'b1, 32'h0000_0040, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D, 1'b1);
    issue(1'b0, 32'h0000_004C, '0, 1'b1);

    // Never-written line, then aliasing of upper address bits.
    issue(1'b0, 32'h0000_0800, '0, 1'b1);
    issue(1'b1, 32'h0000_1000, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1);
    issue(1'b0, 32'h0000_0000, '0, 1'b1);

    // Back-to-back reads presented in the response cycle.
    issue(1'b0, 32'h0000_0040, '0, 1'b1);
    issue(1'b0, 32'h0000_1004, '0, 1'b1);
    step(LAT + 1);

    // Both op bits high for five cycles, then both low: never accepted.
    is_input_valid = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    step(5);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step(3);
    is_input_valid = 1'b0;
    step(1);

    // Reset mid-write discards the write.
    issue(1'b1, 32'h0000_0020, 128'h1, 1'b1);
    issue(1'b1, 32'h0000_0020, 128'hFF, 1'b0);
    step(1);
    do_reset(2);
    step(1);
    issue(1'b0, 32'h0000_0020, '0, 1'b1);

    // Random traffic, biased onto a few lines for read-after-write hits.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:4] = 8'($urandom_range(0, 7));
      rd = {$urandom, $urandom, $urandom, $urandom};
      issue(($urandom_range(0, 1) == 1), ra, rd, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        is_input_valid = 1'b1;
        step(1);
        is_input_valid = 1'b0;
      end
      step($urandom_range(0, 2));
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    step(2);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending responses want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
